// File: rtl/bcd_scan_control.sv
// Eight-digit multiplexed display scan: prescaled position counter,
// active-low anode select and nibble mux. Optional blanking: BLANK_EN.
//
// Ports:
//   refresh_clock  - sole clock, rising edge
//   reset          - synchronous, active-high
//   digit1..digit8 - nibbles for positions 0..7
//   digit_en       - per-position enable (only with BLANK_EN)
//   refreshcounter - current scan position
//   anode          - active-low digit select, one bit low
//   one_digit      - nibble of the selected position
module bcd_scan_control #(
  parameter int DIV_W = 0
) (
  input  logic       refresh_clock,
  input  logic       reset,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic [3:0] digit5,
  input  logic [3:0] digit6,
  input  logic [3:0] digit7,
  input  logic [3:0] digit8,
  input  logic [7:0] digit_en,
  output logic [2:0] refreshcounter,
  output logic [7:0] anode,
  output logic [3:0] one_digit
);

  logic       tick;
  logic [7:0] sel_n;
  logic [3:0] mux_digit;

  // Prescaler starts from zero after reset, so the first
  // advance always comes a full period later.
  generate
    if (DIV_W > 0) begin : g_pre
      logic [DIV_W-1:0] prescaler;

      always_ff @(posedge refresh_clock) begin
        if (reset) prescaler <= '0;
        else       prescaler <= prescaler + 1'b1;
      end

      assign tick = &prescaler;
    end else begin : g_nopre
      assign tick = 1'b1;
    end
  endgenerate

  always_ff @(posedge refresh_clock) begin
    if (reset)     refreshcounter <= 3'd0;
    else if (tick) refreshcounter <= refreshcounter + 3'd1;
  end

  // Both outputs decode the same counter value, so they
  // can never point at different positions.
  assign sel_n = ~(8'b1 << refreshcounter);

  always_comb begin
    mux_digit = digit1;
    unique case (refreshcounter)
      3'd0: mux_digit = digit1;
      3'd1: mux_digit = digit2;
      3'd2: mux_digit = digit3;
      3'd3: mux_digit = digit4;
      3'd4: mux_digit = digit5;
      3'd5: mux_digit = digit6;
      3'd6: mux_digit = digit7;
      3'd7: mux_digit = digit8;
      default: mux_digit = digit1;
    endcase
  end

`ifdef BLANK_EN
  logic pos_en;

  assign pos_en = digit_en[refreshcounter];

  // Disabled positions keep their time slot but light nothing.
  always_comb begin
    anode     = sel_n;
    one_digit = mux_digit;
    if (!pos_en) begin
      anode     = 8'hFF;
      one_digit = 4'hF;
    end
  end
`else
  logic unused_en;

  assign unused_en = ^digit_en;
  assign anode     = sel_n;
  assign one_digit = mux_digit;
`endif

endmodule

// File: tb/tb_bcd_scan_control.sv
// Directed bench for bcd_scan_control: scan order, nibble mux,
// reset mid-scan, prescaler (DIV_W=2) and optional blanking.
module tb_bcd_scan_control;

`ifdef BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       refresh_clock;
  logic       reset;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic [3:0] digit5, digit6, digit7, digit8;
  logic [7:0] digit_en;
  logic [2:0] rc0, rc2;
  logic [7:0] an0, an2;
  logic [3:0] od0, od2;

  int nvec;
  int nerr;

  bcd_scan_control #(.DIV_W(0)) dut0 (
    .refresh_clock (refresh_clock),
    .reset         (reset),
    .digit1        (digit1),
    .digit2        (digit2),
    .digit3        (digit3),
    .digit4        (digit4),
    .digit5        (digit5),
    .digit6        (digit6),
    .digit7        (digit7),
    .digit8        (digit8),
    .digit_en      (digit_en),
    .refreshcounter(rc0),
    .anode         (an0),
    .one_digit     (od0)
  );

  bcd_scan_control #(.DIV_W(2)) dut2 (
    .refresh_clock (refresh_clock),
    .reset         (reset),
    .digit1        (digit1),
    .digit2        (digit2),
    .digit3        (digit3),
    .digit4        (digit4),
    .digit5        (digit5),
    .digit6        (digit6),
    .digit7        (digit7),
    .digit8        (digit8),
    .digit_en      (digit_en),
    .refreshcounter(rc2),
    .anode         (an2),
    .one_digit     (od2)
  );

  initial refresh_clock = 1'b0;
  always #5 refresh_clock = ~refresh_clock;

  typedef struct {
    logic [2:0] rc;
    logic [7:0] an;
    logic [3:0] dig;
    bit         blank;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refresh_clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] ea;
    logic [3:0] ed;
    nvec = 0;
    nerr = 0;

    tbl[0] = '{3'd0, 8'hFE, 4'h3, 1'b0};
    tbl[1] = '{3'd1, 8'hFD, 4'hA, 1'b0};
    tbl[2] = '{3'd2, 8'hFB, 4'h0, 1'b1};
    tbl[3] = '{3'd3, 8'hF7, 4'h0, 1'b1};
    tbl[4] = '{3'd4, 8'hEF, 4'h0, 1'b1};
    tbl[5] = '{3'd5, 8'hDF, 4'h0, 1'b1};
    tbl[6] = '{3'd6, 8'hBF, 4'h3, 1'b0};
    tbl[7] = '{3'd7, 8'h7F, 4'hA, 1'b0};
    tbl[8] = '{3'd0, 8'hFE, 4'h3, 1'b0};

    reset  = 1'b1;
    digit1 = 4'h3; digit2 = 4'hA;
    digit3 = 4'h0; digit4 = 4'h0;
    digit5 = 4'h0; digit6 = 4'h0;
    digit7 = 4'h3; digit8 = 4'hA;
    digit_en = 8'hC3;
    #2;

    // Scan order and nibble mux, one step per clock
    do_reset();
    chk("rst_rc2", 32'(rc2), 32'd0);
    for (int i = 0; i < 9; i++) begin
      ea = (BLANK && tbl[i].blank) ? 8'hFF : tbl[i].an;
      ed = (BLANK && tbl[i].blank) ? 4'hF : tbl[i].dig;
      chk($sformatf("scan%0d_rc", i), 32'(rc0), 32'(tbl[i].rc));
      chk($sformatf("scan%0d_an", i), 32'(an0), 32'(ea));
      chk($sformatf("scan%0d_dig", i), 32'(od0), 32'(ed));
      if (i < 8) step();
    end

    // Same-cycle response to a digit change at position 0
    do_reset();
    digit1 = 4'h6;
    #1;
    chk("comb_d6", 32'(od0), 32'h6);
    digit1 = 4'hB;
    #1;
    chk("comb_dB", 32'(od0), 32'hB);
    chk("comb_rc", 32'(rc0), 32'd0);
    digit1 = 4'h3;

    // Reset while at position 5
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("mid_rc5", 32'(rc0), 32'd5);
    chk("mid_rc2", 32'(rc2), 32'd1);
    do_reset();
    chk("mid_rst_rc", 32'(rc0), 32'd0);
    chk("mid_rst_an", 32'(an0), 32'hFE);
    chk("mid_rst_dig", 32'(od0), 32'(digit1));
    // Full prescale period before the first advance
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("mid_pre%0d", k), 32'(rc2),
          (k < 4) ? 32'd0 : 32'd1);
    end

    // Prescaled scan: 32 clocks return to position 0
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      chk($sformatf("div_rc0_%0d", k), 32'(rc0), 32'(k % 8));
      chk($sformatf("div_rc2_%0d", k), 32'(rc2), 32'((k / 4) % 8));
      if (k % 4 == 0)
        chk($sformatf("div_an0_%0d", k), 32'(an2),
            (BLANK && ((k / 4) % 8) inside {[2:5]}) ? 32'hFF
              : 32'(~(8'b1 << ((k / 4) % 8)) & 8'hFF));
      if (k < 32) step();
    end

    // All positions enabled: blanking must not occur
    digit_en = 8'hFF;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("en_an%0d", i), 32'(an0), 32'(tbl[i].an));
      chk($sformatf("en_dig%0d", i), 32'(od0), 32'(tbl[i].dig));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
